fetch_prefetch_unit: RTL



---
 rtl/fetch_prefetch_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: PC generation plus a DEPTH-entry in-order prefetch buffer.
// Latency: request to memory is combinational from pc; a response at cycle N is presented to decode at N+1.
// Backpressure: issue stalls when buffer occupancy plus pending discards reaches DEPTH; decode stalls via IF_ID_ready.
//
// Ports:
//   clk, reset                   rising-edge clock, asynchronous active-high reset
//   redirect_valid/redirect_pc   branch/jump redirect; flushes the buffer, target word-aligned
//   imem_req/imem_addr/imem_ready    fetch request handshake (address = current pc)
//   imem_rvalid/imem_rdata       in-order fetch responses, one or more cycles after issue
//   IF_ID_valid/pc/inst/ready    head-of-buffer handshake towards decode
//   protocol_err                 sticky flag: response arrived with nothing outstanding
// Optional feature macro FETCH_PERF_EN adds saturating counters perf_fetched, perf_redirects, perf_starve.
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic            IF_ID_valid,
    output logic [XLEN-1:0] IF_ID_pc,
    output logic [XLEN-1:0] IF_ID_inst,
    input  logic            IF_ID_ready,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_redirects,
    output logic [31:0]     perf_starve,
`endif
    output logic            protocol_err
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] pc;
    logic [PW-1:0]   head, tail, fill_ptr;
    logic [CW-1:0]   count;      // allocated entries
    logic [CW-1:0]   unfilled;   // allocated entries still waiting for data
    logic [CW-1:0]   drop_cnt;   // in-flight responses belonging to flushed requests
    logic [XLEN-1:0] ent_pc   [DEPTH];
    logic [XLEN-1:0] ent_inst [DEPTH];
    logic [DEPTH-1:0] ent_filled;

    logic            issue, pop, rsp_fill, rsp_drop, rsp_err;
    logic [CW:0]     occ_sum, drop_sum, drop_next;
    logic [XLEN-1:0] redirect_aligned;

    always_comb begin
        // Pending discards occupy memory-side slots, so they count against the issue budget.
        occ_sum          = {1'b0, count} + {1'b0, drop_cnt};
        imem_req         = !reset && !redirect_valid && (occ_sum < (CW+1)'(DEPTH));
        imem_addr        = pc;
        issue            = imem_req && imem_ready;

        IF_ID_valid      = (count != '0) && ent_filled[head];
        IF_ID_pc         = IF_ID_valid ? ent_pc[head]   : '0;
        IF_ID_inst       = IF_ID_valid ? ent_inst[head] : '0;
        pop              = IF_ID_valid && IF_ID_ready;

        rsp_drop         = imem_rvalid && (drop_cnt != '0);
        rsp_fill         = imem_rvalid && (drop_cnt == '0) && (unfilled != '0);
        rsp_err          = imem_rvalid && (drop_cnt == '0) && (unfilled == '0);

        // On redirect every unfilled entry becomes a response to discard; a response
        // landing in the redirect cycle itself is consumed from that total.
        drop_sum         = {1'b0, unfilled} + {1'b0, drop_cnt};
        drop_next        = (imem_rvalid && (drop_sum != '0)) ? drop_sum - (CW+1)'(1) : drop_sum;
        redirect_aligned = redirect_pc & ~XLEN'(3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            head         <= '0;
            tail         <= '0;
            fill_ptr     <= '0;
            count        <= '0;
            unfilled     <= '0;
            drop_cnt     <= '0;
            ent_filled   <= '0;
            protocol_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_pc[i]   <= '0;
                ent_inst[i] <= '0;
            end
        end else begin
            if (rsp_err)
                protocol_err <= 1'b1;

            if (redirect_valid) begin
                pc         <= redirect_aligned;
                head       <= '0;
                tail       <= '0;
                fill_ptr   <= '0;
                count      <= '0;
                unfilled   <= '0;
                ent_filled <= '0;
                drop_cnt   <= CW'(drop_next);
            end else begin
                if (issue) begin
                    ent_pc[tail]     <= pc;
                    ent_filled[tail] <= 1'b0;
                    tail             <= tail + PW'(1);
                    pc               <= pc + XLEN'(PC_STEP);
                end
                // fill_ptr never equals tail while an unfilled entry exists, so no
                // write conflict with the allocation above.
                if (rsp_fill) begin
                    ent_inst[fill_ptr]   <= imem_rdata;
                    ent_filled[fill_ptr] <= 1'b1;
                    fill_ptr             <= fill_ptr + PW'(1);
                end
                if (rsp_drop)
                    drop_cnt <= drop_cnt - CW'(1);
                if (pop)
                    head <= head + PW'(1);
                count    <= count + CW'(issue) - CW'(pop);
                unfilled <= unfilled + CW'(issue) - CW'(rsp_fill);
            end
        end
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
            perf_starve    <= '0;
        end else begin
            if (pop && perf_fetched != '1)
                perf_fetched <= perf_fetched + 32'd1;
            if (redirect_valid && perf_redirects != '1)
                perf_redirects <= perf_redirects + 32'd1;
            if (IF_ID_ready && !IF_ID_valid && perf_starve != '1)
                perf_starve <= perf_starve + 32'd1;
        end
    end
`endif

endmodule
